// File: rtl/spc_pkg.sv
// spc_pkg: shared types and constants for the serial parity checker feeder
package spc_pkg;
    localparam int DEF_WIDTH = 8;
    localparam bit EVEN_PAR = 1'b0;
    localparam bit ODD_PAR = 1'b1;
    typedef enum logic [1:0] {IDLE, SHIFT, PAR} state_t;
endpackage

// File: rtl/spc_serializer.sv
// spc_serializer: parallel word to LSB-first serial frame with trailing parity bit
module spc_serializer
    import spc_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter bit PARITY_ODD = EVEN_PAR
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             x,
    output logic             x_valid,
    output logic             frame_start,
    output logic             frame_end
);
    localparam int CW = $clog2(WIDTH + 1);
    state_t r_state, w_next;
    logic [WIDTH-1:0] r_shreg;
    logic [CW-1:0] r_cnt;
    logic r_par, r_x, r_x_valid, r_fs, r_fe;
    logic w_accept, w_last;
    assign in_ready = !rst && (r_state != SHIFT);
    assign w_accept = in_valid && in_ready;
    assign w_last = r_cnt == CW'(WIDTH - 1);
    assign x = r_x;
    assign x_valid = r_x_valid;
    assign frame_start = r_fs;
    assign frame_end = r_fe;
    // Next state: IDLE and PAR both load a new word on accept, SHIFT runs WIDTH bits
    always_comb begin
        w_next = (r_state == SHIFT) ? (w_last ? PAR : SHIFT) : (w_accept ? SHIFT : IDLE);
    end
    // State, shifter, counter and registered serial outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_shreg <= '0;
            r_cnt <= '0;
            r_par <= 1'b0;
            r_x <= 1'b0;
            r_x_valid <= 1'b0;
            r_fs <= 1'b0;
            r_fe <= 1'b0;
        end else begin
            r_state <= w_next;
            r_x <= (r_state == SHIFT) ? r_shreg[0] : (r_state == PAR) ? r_par : 1'b0;
            r_x_valid <= r_state != IDLE;
            r_fs <= (r_state == SHIFT) && (r_cnt == '0);
            r_fe <= r_state == PAR;
            if (w_accept) begin
                r_shreg <= in_data;
                r_par <= ^in_data ^ PARITY_ODD;
                r_cnt <= '0;
            end else if (r_state == SHIFT) begin
                r_shreg <= r_shreg >> 1;
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end
endmodule

// File: tb/tb_spc_serializer.sv
// tb_spc_serializer: scoreboard bench driving even- and odd-parity serializers in lockstep
module tb_spc_serializer;
    import spc_pkg::*;
    typedef struct {logic [7:0] data; logic pe; logic po;} vec_t;
    typedef struct {logic xe; logic xo; logic fs; logic fe;} item_t;
    logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0;
    logic [7:0] in_data = '0;
    logic rdy_e, x_e, xv_e, fs_e, fe_e;
    logic rdy_o, x_o, xv_o, fs_o, fe_o;
    item_t q[$];
    vec_t tbl[6];
    int checks = 0, failures = 0;
    int run = 0, max_run = 0;
    logic p_e = 1'b0, p_o = 1'b0;
    always #5 clk = ~clk;
    spc_serializer #(.WIDTH(8), .PARITY_ODD(EVEN_PAR)) dut_e (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_e), .in_data(in_data),
        .x(x_e), .x_valid(xv_e), .frame_start(fs_e), .frame_end(fe_e)
    );
    spc_serializer #(.WIDTH(8), .PARITY_ODD(ODD_PAR)) dut_o (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_o), .in_data(in_data),
        .x(x_o), .x_valid(xv_o), .frame_start(fs_o), .frame_end(fe_o)
    );
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask
    task automatic send(input vec_t v);
        bit done = 0;
        in_valid = 1'b1;
        in_data = v.data;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (rdy_e) begin
                @(posedge clk);
                for (int b = 0; b < 8; b++) q.push_back('{v.data[b], v.data[b], b == 0, 1'b0});
                q.push_back('{v.pe, v.po, 1'b0, 1'b1});
                #1;
                done = 1;
            end
        end
        if (!done) chk("accept_timeout", 0, 1);
    endtask
    initial begin
        item_t it;
        logic exp_rdy;
        @(posedge clk);
        forever begin
            @(negedge clk);
            exp_rdy = !rst && q.size() <= 2;
            chk("in_ready_e", rdy_e, exp_rdy);
            chk("in_ready_o", rdy_o, exp_rdy);
            if (xv_e) begin
                if (q.size() == 0) chk("unexpected_valid", 1, 0);
                else begin
                    it = q.pop_front();
                    chk("x_even", x_e, it.xe);
                    chk("x_odd", x_o, it.xo);
                    chk("x_valid_odd", xv_o, 1);
                    chk("frame_start", {fs_e, fs_o}, {it.fs, it.fs});
                    chk("frame_end", {fe_e, fe_o}, {it.fe, it.fe});
                    p_e = p_e ^ x_e;
                    p_o = p_o ^ x_o;
                    if (it.fe) begin
                        chk("checker_even_parity", p_e, 0);
                        chk("checker_odd_parity", p_o, 1);
                        p_e = 1'b0;
                        p_o = 1'b0;
                    end
                    run++;
                    if (run > max_run) max_run = run;
                end
            end else begin
                chk("idle_outputs", {x_e, x_o, xv_o, fs_e, fs_o, fe_e, fe_o}, 0);
                run = 0;
            end
            if (rst) begin
                q.delete();
                p_e = 1'b0;
                p_o = 1'b0;
            end
        end
    end
    initial begin
        tbl[0] = '{8'hA5, 1'b0, 1'b1};
        tbl[1] = '{8'h01, 1'b1, 1'b0};
        tbl[2] = '{8'hFF, 1'b0, 1'b1};
        tbl[3] = '{8'h00, 1'b0, 1'b1};
        tbl[4] = '{8'h3C, 1'b0, 1'b1};
        tbl[5] = '{8'h07, 1'b1, 1'b0};
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        send(tbl[0]);
        in_valid = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        send(tbl[1]);
        in_data = 8'h5A;
        repeat (4) @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1 max_run = 0;
        for (int i = 2; i <= 4; i++) send(tbl[i]);
        in_valid = 1'b0;
        repeat (30) @(posedge clk);
        chk("stream_run_length", max_run, 27);
        #1;
        send(tbl[0]);
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("abort_x_valid", xv_e, 0);
        chk("abort_ready", rdy_e, 1);
        @(posedge clk);
        #1;
        send(tbl[5]);
        in_valid = 1'b0;
        repeat (12) @(posedge clk);
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk("queue_drained", q.size(), 0);
        chk("checker_idle_state", {p_e, p_o}, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
